// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and byte-lane masks.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_RMW_WRITE = 1'b1
    } lsu_state_t;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Halves need an even address, words a multiple of four; bytes always fit.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = offset[0];
            default:   is_misaligned = |offset;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory bus between datapath, load/store unit and memory.
interface lsu_if;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_address;
    logic [31:0] req_store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;
    logic        fault;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output req_read, req_write, req_size, req_signed, req_address, req_store_data,
        output mem_read_data,
        input  load_data, stall, misaligned, fault, mem_address, mem_write, mem_write_data
    );

    modport slave (
        input  req_read, req_write, req_size, req_signed, req_address, req_store_data,
        input  mem_read_data,
        output load_data, stall, misaligned, fault, mem_address, mem_write, mem_write_data
    );
endinterface

// File: rtl/lane_align.sv
// Byte-lane steering: MERGE=0 extracts and extends a load lane, MERGE=1 merges store data into a word.
module lane_align
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0,
    parameter bit MERGE      = 1'b0
) (
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] result
);
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [3:0]  lane_mask;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign byte_lane = BIG_ENDIAN ? (2'd3 - offset) : offset;
    assign half_lane = BIG_ENDIAN ? ~offset[1] : offset[1];
    assign lane_byte = word[{byte_lane, 3'b000} +: 8];
    assign lane_half = word[{half_lane, 4'b0000} +: 16];

    always_comb begin
        case (size)
            SIZE_BYTE: lane_mask = MASK_BYTE << byte_lane;
            SIZE_HALF: lane_mask = MASK_HALF << {half_lane, 1'b0};
            default:   lane_mask = MASK_WORD;
        endcase
    end

    generate
        if (MERGE) begin : g_merge
            logic [31:0] lane_src;
            logic        unused_merge;

            // Replicating the sub-word across all lanes lets the mask alone pick the target.
            always_comb begin
                case (size)
                    SIZE_BYTE: lane_src = {4{store_data[7:0]}};
                    SIZE_HALF: lane_src = {2{store_data[15:0]}};
                    default:   lane_src = store_data;
                endcase
            end

            for (genvar gi = 0; gi < 4; gi++) begin : g_lane
                assign result[8*gi +: 8] = lane_mask[gi] ? lane_src[8*gi +: 8] : word[8*gi +: 8];
            end

            assign unused_merge = ^{sign_ext, lane_byte, lane_half};
        end else begin : g_extract
            logic unused_extract;

            always_comb begin
                case (size)
                    SIZE_BYTE: result = {{24{sign_ext & lane_byte[7]}}, lane_byte};
                    SIZE_HALF: result = {{16{sign_ext & lane_half[15]}}, lane_half};
                    default:   result = word;
                endcase
            end

            assign unused_extract = ^{store_data, lane_mask};
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit: single-cycle loads and word stores, 2-cycle read-modify-write for sb/sh.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN        = 1'b0,
    parameter bit FAULT_ON_MISALIGN = 1'b1
) (
    input  logic clock,
    input  logic clear,
    lsu_if.slave bus
);
    lsu_state_t  state_reg;
    logic [31:0] rmw_addr_reg;
    logic [31:0] rmw_word_reg;
    logic        fault_reg;

    logic [1:0]  size_eff;
    logic [1:0]  offset_eff;
    logic [31:0] aligned_addr;
    logic        active;
    logic        bad_align;
    logic        suppress;
    logic        is_sub;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    logic [31:0] load_data_next;
    logic        stall_next;
    logic        misaligned_next;
    logic [31:0] mem_address_next;
    logic        mem_write_next;
    logic [31:0] mem_write_data_next;

    assign size_eff     = (bus.req_size == 2'b11) ? SIZE_WORD : bus.req_size;
    assign active       = bus.req_read | bus.req_write;
    assign bad_align    = is_misaligned(size_eff, bus.req_address[1:0]);
    assign suppress     = active & bad_align & (state_reg == ST_IDLE) & FAULT_ON_MISALIGN;
    assign is_sub       = (size_eff != SIZE_WORD);
    assign aligned_addr = {bus.req_address[31:2], 2'b00};

    // Without fault suppression, misaligned accesses proceed with the offending low bits dropped.
    always_comb begin
        offset_eff = bus.req_address[1:0];
        case (size_eff)
            SIZE_BYTE: offset_eff = bus.req_address[1:0];
            SIZE_HALF: offset_eff = {bus.req_address[1], 1'b0};
            default:   offset_eff = 2'b00;
        endcase
    end

    lane_align #(.BIG_ENDIAN(BIG_ENDIAN), .MERGE(1'b0)) u_load_align (
        .size       (size_eff),
        .sign_ext   (bus.req_signed),
        .offset     (offset_eff),
        .word       (bus.mem_read_data),
        .store_data (bus.req_store_data),
        .result     (load_value)
    );

    lane_align #(.BIG_ENDIAN(BIG_ENDIAN), .MERGE(1'b1)) u_store_merge (
        .size       (size_eff),
        .sign_ext   (bus.req_signed),
        .offset     (offset_eff),
        .word       (bus.mem_read_data),
        .store_data (bus.req_store_data),
        .result     (merged_word)
    );

    // Outputs are gated by clear so a reset mid-RMW can never leak a write to memory.
    always_comb begin
        load_data_next      = 32'h0;
        stall_next          = 1'b0;
        misaligned_next     = 1'b0;
        mem_address_next    = 32'h0;
        mem_write_next      = 1'b0;
        mem_write_data_next = 32'h0;
        if (!clear) begin
            if (state_reg == ST_RMW_WRITE) begin
                mem_address_next    = rmw_addr_reg;
                mem_write_next      = 1'b1;
                mem_write_data_next = rmw_word_reg;
            end else begin
                mem_address_next = aligned_addr;
                misaligned_next  = active & bad_align;
                if (!suppress) begin
                    if (bus.req_write) begin
                        if (is_sub) begin
                            stall_next = 1'b1;
                        end else begin
                            mem_write_next      = 1'b1;
                            mem_write_data_next = bus.req_store_data;
                        end
                    end else if (bus.req_read) begin
                        load_data_next = load_value;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg    <= ST_IDLE;
            rmw_addr_reg <= 32'h0;
            rmw_word_reg <= 32'h0;
            fault_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (suppress) begin
                        fault_reg <= 1'b1;
                    end
                    if (bus.req_write && is_sub && !suppress) begin
                        rmw_word_reg <= merged_word;
                        rmw_addr_reg <= aligned_addr;
                        state_reg    <= ST_RMW_WRITE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.load_data      = load_data_next;
    assign bus.stall          = stall_next;
    assign bus.misaligned     = misaligned_next;
    assign bus.fault          = fault_reg;
    assign bus.mem_address    = mem_address_next;
    assign bus.mem_write      = mem_write_next;
    assign bus.mem_write_data = mem_write_data_next;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word memory (comb read, negedge write).
module tb_load_store_unit;
    logic clock;
    logic clear;
    int   checks;
    int   fails;

    lsu_if bus ();

    load_store_unit #(.BIG_ENDIAN(1'b0), .FAULT_ON_MISALIGN(1'b1)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    logic [31:0] mem [0:15];
    logic        in_range;
    logic [3:0]  idx;

    assign in_range          = (bus.mem_address[31:6] == 26'h0400400);
    assign idx               = bus.mem_address[5:2];
    assign bus.mem_read_data = in_range ? mem[idx] : 32'h0;

    always @(negedge clock) begin
        if (bus.mem_write && in_range) mem[idx] <= bus.mem_write_data;
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request shortly after posedge; outputs are checked 2 time units later.
    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] data);
        bus.req_read       = rd;
        bus.req_write      = wr;
        bus.req_size       = sz;
        bus.req_signed     = sg;
        bus.req_address    = addr;
        bus.req_store_data = data;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic after_negedge();
        @(negedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h0000_0064;
        mem[1] = 32'h0000_00C8;

        clear = 1'b1;
        drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h1001_0003, 32'h0);
        check("rst_mem_address", bus.mem_address, 32'h0);
        check("rst_load_data", bus.load_data, 32'h0);
        check("rst_stall", {31'h0, bus.stall}, 32'h0);
        check("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
        check("rst_mem_write_data", bus.mem_write_data, 32'h0);
        check("rst_misaligned", {31'h0, bus.misaligned}, 32'h0);
        check("rst_fault", {31'h0, bus.fault}, 32'h0);

        next_cycle();
        clear = 1'b0;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
        $display("lw   0x10010004 -> %h", bus.load_data);
        check("lw_data", bus.load_data, 32'h0000_00C8);
        check("lw_stall", {31'h0, bus.stall}, 32'h0);
        check("lw_mem_write", {31'h0, bus.mem_write}, 32'h0);
        check("lw_mem_address", bus.mem_address, 32'h1001_0004);

        next_cycle();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h1001_0001, 32'h0000_00AB);
        $display("sb   0xAB -> 0x10010001 cycle1 stall=%b", bus.stall);
        check("sb_c1_stall", {31'h0, bus.stall}, 32'h1);
        check("sb_c1_mem_write", {31'h0, bus.mem_write}, 32'h0);
        check("sb_c1_mem_address", bus.mem_address, 32'h1001_0000);
        next_cycle();
        #2;
        $display("sb   cycle2 mem_write=%b data=%h", bus.mem_write, bus.mem_write_data);
        check("sb_c2_stall", {31'h0, bus.stall}, 32'h0);
        check("sb_c2_mem_write", {31'h0, bus.mem_write}, 32'h1);
        check("sb_c2_write_data", bus.mem_write_data, 32'h0000_AB64);
        after_negedge();
        check("sb_mem_word", mem[0], 32'h0000_AB64);

        next_cycle();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0001, 32'h0);
        $display("lbu  0x10010001 -> %h", bus.load_data);
        check("lbu_data", bus.load_data, 32'h0000_00AB);
        next_cycle();
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h1001_0001, 32'h0);
        $display("lb   0x10010001 -> %h", bus.load_data);
        check("lb_data", bus.load_data, 32'hFFFF_FFAB);

        next_cycle();
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h1001_0006, 32'h0000_8001);
        $display("sh   0x8001 -> 0x10010006 cycle1 stall=%b", bus.stall);
        check("sh_c1_stall", {31'h0, bus.stall}, 32'h1);
        next_cycle();
        #2;
        $display("sh   cycle2 mem_write=%b data=%h", bus.mem_write, bus.mem_write_data);
        check("sh_c2_mem_write", {31'h0, bus.mem_write}, 32'h1);
        check("sh_c2_write_data", bus.mem_write_data, 32'h8001_00C8);
        check("sh_c2_mem_address", bus.mem_address, 32'h1001_0004);
        after_negedge();
        check("sh_mem_word", mem[1], 32'h8001_00C8);
        next_cycle();
        drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h1001_0006, 32'h0);
        $display("lh   0x10010006 -> %h", bus.load_data);
        check("lh_data", bus.load_data, 32'hFFFF_8001);
        next_cycle();
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h1001_0006, 32'h0);
        $display("lhu  0x10010006 -> %h", bus.load_data);
        check("lhu_data", bus.load_data, 32'h0000_8001);

        next_cycle();
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h1234_5678);
        $display("sw   0x12345678 -> 0x10010008 stall=%b mem_write=%b", bus.stall, bus.mem_write);
        check("sw_stall", {31'h0, bus.stall}, 32'h0);
        check("sw_mem_write", {31'h0, bus.mem_write}, 32'h1);
        check("sw_write_data", bus.mem_write_data, 32'h1234_5678);
        after_negedge();
        check("sw_mem_word", mem[2], 32'h1234_5678);
        next_cycle();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0);
        $display("lw   0x10010008 -> %h", bus.load_data);
        check("lw_back_data", bus.load_data, 32'h1234_5678);

        next_cycle();
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h1001_000C, 32'hCAFE_F00D);
        $display("rd+wr word 0x1001000C mem_write=%b load_data=%h", bus.mem_write, bus.load_data);
        check("rdwr_mem_write", {31'h0, bus.mem_write}, 32'h1);
        check("rdwr_load_data", bus.load_data, 32'h0);
        after_negedge();
        check("rdwr_mem_word", mem[3], 32'hCAFE_F00D);

        next_cycle();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h1001_0007, 32'h0);
        $display("idle addr 0x10010007 mem_address=%h", bus.mem_address);
        check("idle_mem_address", bus.mem_address, 32'h1001_0004);
        check("idle_load_data", bus.load_data, 32'h0);
        check("idle_mem_write", {31'h0, bus.mem_write}, 32'h0);

        next_cycle();
        drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h1001_0003, 32'h0);
        $display("lh   0x10010003 misaligned=%b load_data=%h", bus.misaligned, bus.load_data);
        check("mis_lh_flag", {31'h0, bus.misaligned}, 32'h1);
        check("mis_lh_load_data", bus.load_data, 32'h0);
        check("mis_lh_fault_before", {31'h0, bus.fault}, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0);
        check("mis_fault_set", {31'h0, bus.fault}, 32'h1);
        repeat (10) next_cycle();
        $display("fault after 10 idle cycles=%b", bus.fault);
        check("mis_fault_sticky", {31'h0, bus.fault}, 32'h1);
        next_cycle();
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h1001_0002, 32'hDEAD_BEEF);
        $display("sw   0xDEADBEEF -> 0x10010002 misaligned=%b mem_write=%b", bus.misaligned, bus.mem_write);
        check("mis_sw_flag", {31'h0, bus.misaligned}, 32'h1);
        check("mis_sw_mem_write", {31'h0, bus.mem_write}, 32'h0);
        check("mis_sw_stall", {31'h0, bus.stall}, 32'h0);
        after_negedge();
        check("mis_sw_mem_word", mem[0], 32'h0000_AB64);

        next_cycle();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h1001_0000, 32'h0000_0055);
        check("clr_sb_c1_stall", {31'h0, bus.stall}, 32'h1);
        next_cycle();
        #2;
        check("clr_sb_c2_mem_write", {31'h0, bus.mem_write}, 32'h1);
        clear = 1'b1;
        #1;
        $display("clear mid-RMW mem_write=%b stall=%b fault=%b", bus.mem_write, bus.stall, bus.fault);
        check("clr_mem_write", {31'h0, bus.mem_write}, 32'h0);
        check("clr_stall", {31'h0, bus.stall}, 32'h0);
        check("clr_fault", {31'h0, bus.fault}, 32'h0);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0);
        after_negedge();
        check("clr_mem_word", mem[0], 32'h0000_AB64);
        next_cycle();
        clear = 1'b0;
        #2;
        check("post_clr_stall", {31'h0, bus.stall}, 32'h0);
        check("post_clr_mem_write", {31'h0, bus.mem_write}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle datapath and the word-wide data memory (combinational read, write on negedge clock).
- Turns MIPS byte, halfword and word loads/stores (lb, lbu, lh, lhu, lw, sb, sh, sw) into whole-word memory accesses.
- Sub-word stores run as a 2-cycle read-modify-write (RMW) and stall the datapath for one cycle.
- Loads and aligned sw complete in a single cycle.

Parameters:
- BIG_ENDIAN, 0, byte-lane order. 0: byte 0 = bits 7:0; 1: byte 0 = bits 31:24.
- FAULT_ON_MISALIGN, 1, behaviour on misalignment. 1: misaligned access suppressed and flagged; 0: low address bits forced to zero and access proceeds.

Ports:
- clock  in  1  system clock; block state updates on posedge.
- clear  in  1  asynchronous, active-high reset.
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal (treated as word).
- req_signed  in  1  loads only. 1 = sign-extend, 0 = zero-extend.
- req_address  in  32  byte address.
- req_store_data  in  32  store value; the low-order byte or half is used for sub-word stores.
- load_data  out  32  extended load result (combinational).
- stall  out  1  datapath must hold PC and pipeline inputs this cycle.
- misaligned  out  1  current request is misaligned (combinational).
- fault  out  1  sticky misalignment flag, cleared only by clear.
- mem_address  out  32  word-aligned address to data memory.
- mem_write  out  1  memory write enable.
- mem_write_data  out  32  word written to memory.
- mem_read_data  in  32  word read from memory.

Behaviour:
- FSM states: IDLE, RMW_WRITE. Registers: state, rmw_addr[31:0], rmw_word[31:0], fault.
- Reset (clear high, asynchronous):
  - state=IDLE, rmw_addr=0, rmw_word=0, fault=0.
  - Outputs follow immediately: stall=0, mem_write=0, mem_write_data=0, mem_address=0, load_data=0, misaligned=0.
- Alignment rules:
  - Half requires addr[0]=0. Word requires addr[1:0]=00. Byte is always aligned.
  - misaligned = (req_read|req_write) & state==IDLE & alignment rule violated.
  - When misaligned and FAULT_ON_MISALIGN=1: mem_write=0, load_data=0, stall=0, and fault is set on the next posedge.
- IDLE, load:
  - mem_address = {addr[31:2],2'b00}.
  - The lane selected by addr[1:0] is extracted from mem_read_data, then sign- or zero-extended per req_signed.
  - Word loads ignore req_signed. Zero latency, stall=0.
- IDLE, aligned sw:
  - mem_write=1, mem_write_data=req_store_data, stall=0.
  - The memory captures the word on the negedge of the same cycle.
- IDLE, sb/sh:
  - Cycle 1: mem_address = aligned address, mem_write=0, stall=1.
  - On posedge, the merged word (mem_read_data with the target lane(s) replaced by req_store_data[7:0] or [15:0]) is latched into rmw_word, the aligned address into rmw_addr, and state goes to RMW_WRITE.
- RMW_WRITE:
  - Cycle 2: mem_address=rmw_addr, mem_write=1, mem_write_data=rmw_word, stall=0.
  - Request inputs are ignored (the datapath still presents the same instruction).
  - Next state IDLE unconditionally. Total latency for sub-word stores is 2 cycles, 1 stall cycle.
- req_read & req_write together: treated as a store, no load result (load_data=0).
- No request: mem_address=req_address aligned, mem_write=0, load_data=0.
- Out-of-range addresses pass through unchanged; the memory decodes range and returns 0.
- clear asserted during RMW_WRITE:
  - state returns to IDLE asynchronously and mem_write drops immediately, so no write is issued.
  - No partial write ever reaches memory.
- Lane mapping is mirrored when BIG_ENDIAN=1: lane index becomes 3-addr[1:0] for bytes and 1-addr[1] for halves.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state encodings ST_IDLE/ST_RMW_WRITE;
  - lane-mask constants.
- One natural sub-module, lane_align: purely combinational.
  - Computes the extract+extend result for loads.
  - Computes the merge of store data into a read word.
  - Instantiated once for each path (load and store merge).

Test Plan:
Memory preloaded with M[0x10010000]=0x00000064, M[0x10010004]=0x000000C8; BIG_ENDIAN=0.
- lw 0x10010004 -> load_data=0x000000C8, stall=0, mem_write=0 throughout.
- sb 0x000000AB to 0x10010001 -> stall=1 for exactly one cycle, then mem_write=1 with 0x0000AB64; follow with lbu 0x10010001 -> 0x000000AB and lb -> 0xFFFFFFAB.
- sh 0x00008001 to 0x10010006 -> M[0x10010004]=0x800100C8; lh 0x10010006 -> 0xFFFF8001; lhu -> 0x00008001.
- sw 0x12345678 to 0x10010008 -> no stall, written same cycle; lw back returns 0x12345678.
- lh 0x10010003 -> misaligned=1, load_data=0, fault=1 from the next cycle and still 1 after 10 idle cycles; sw 0xDEADBEEF to 0x10010002 -> no memory change.
- sb to 0x10010000 with clear pulsed mid-RMW_WRITE (before negedge) -> mem_write low, state IDLE, stall=0, fault=0.
